jtroadf_colmix: RTL and testbench



---
 rtl/jtroadf_colmix_if.sv | 38 +++
 rtl/jtroadf_colmix.sv | 88 ++++++++
 tb/tb_jtroadf_colmix.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/jtroadf_colmix_if.sv
// Pixel/blanking/PROM-download bundle between the video layers and jtroadf_colmix.
// JTROADF_GFXEN_EN adds the per-layer enable bits gfx_en[1:0].
interface jtroadf_colmix_if;
    logic       pxl_cen;
    logic       LHBL;
    logic       LVBL;
    logic [3:0] scr_pxl;
    logic [3:0] obj_pxl;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic       prog_en;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       LHBL_dly;
    logic       LVBL_dly;
`ifdef JTROADF_GFXEN_EN
    logic [1:0] gfx_en;

    modport master (
        output pxl_cen, LHBL, LVBL, scr_pxl, obj_pxl, prog_addr, prog_data, prog_en, gfx_en,
        input  red, green, blue, LHBL_dly, LVBL_dly
    );
    modport slave (
        input  pxl_cen, LHBL, LVBL, scr_pxl, obj_pxl, prog_addr, prog_data, prog_en, gfx_en,
        output red, green, blue, LHBL_dly, LVBL_dly
    );
`else
    modport master (
        output pxl_cen, LHBL, LVBL, scr_pxl, obj_pxl, prog_addr, prog_data, prog_en,
        input  red, green, blue, LHBL_dly, LVBL_dly
    );
    modport slave (
        input  pxl_cen, LHBL, LVBL, scr_pxl, obj_pxl, prog_addr, prog_data, prog_en,
        output red, green, blue, LHBL_dly, LVBL_dly
    );
`endif
endinterface

// File: rtl/jtroadf_colmix.sv
// Colour mixer: sprite-over-tile priority, 32x8 palette PROM, RGB expansion, blanking delay.
// Optional macro JTROADF_GFXEN_EN adds gfx_en[1:0] layer enables (same latency either way).
module jtroadf_colmix #(
    parameter int BLNK_DLY = 3
) (
    input  logic             clk,
    input  logic             rst,
    jtroadf_colmix_if.slave  bus
);

    // Palette words sitting between the PROM read and the final stage; extra
    // entries pad the pixel path so its latency matches BLNK_DLY.
    localparam int NDAT = (BLNK_DLY > 3) ? BLNK_DLY - 2 : 1;

    function automatic logic [11:0] expand(input logic [7:0] d);
        return {d[2:0], d[2], d[5:3], d[5], d[7:6], d[7:6]};
    endfunction

    logic [7:0]                prom_mem [32];
    logic [3:0]                scr;
    logic [3:0]                obj;
    logic [4:0]                pal_idx;
    logic [4:0]                rd_idx;
    logic [4:0]                idx_p1_q, idx_p1_d;
    logic [NDAT-1:0][7:0]      dat_p2_q, dat_p2_d;
    logic [11:0]               rgb_p3_q, rgb_p3_d;
    logic [BLNK_DLY-1:0]       hbl_q, hbl_d;
    logic [BLNK_DLY-1:0]       vbl_q, vbl_d;

    // PROM download is free-running on clk; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.prog_en) prom_mem[bus.prog_addr] <= bus.prog_data;
    end

    // Stage 1 input: layer gating and priority
    always_comb begin
        scr = bus.scr_pxl;
        obj = bus.obj_pxl;
`ifdef JTROADF_GFXEN_EN
        if (!bus.gfx_en[0]) scr = 4'd0;
        if (!bus.gfx_en[1]) obj = 4'd0;
`endif
        pal_idx = (obj != 4'd0) ? {1'b0, obj} : {1'b1, scr};
        // With the shortest delay the priority result addresses the PROM directly.
        rd_idx  = (BLNK_DLY >= 3) ? idx_p1_q : pal_idx;
    end

    always_comb begin
        idx_p1_d = idx_p1_q;
        dat_p2_d = dat_p2_q;
        rgb_p3_d = rgb_p3_q;
        hbl_d    = hbl_q;
        vbl_d    = vbl_q;
        if (bus.pxl_cen) begin
            // Stage 1 -> 2: registered PROM read (old data on a same-address write)
            idx_p1_d    = pal_idx;
            dat_p2_d[0] = prom_mem[rd_idx];
            for (int i = NDAT - 1; i > 0; i--) dat_p2_d[i] = dat_p2_q[i-1];
            // Stage 3: expansion, masked by the blanking bit entering the last tap
            rgb_p3_d = (hbl_q[BLNK_DLY-2] & vbl_q[BLNK_DLY-2]) ? expand(dat_p2_q[NDAT-1]) : 12'd0;
            hbl_d    = {hbl_q[BLNK_DLY-2:0], bus.LHBL};
            vbl_d    = {vbl_q[BLNK_DLY-2:0], bus.LVBL};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_p1_q <= '0;
            dat_p2_q <= '0;
            rgb_p3_q <= '0;
            hbl_q    <= '0;
            vbl_q    <= '0;
        end else begin
            idx_p1_q <= idx_p1_d;
            dat_p2_q <= dat_p2_d;
            rgb_p3_q <= rgb_p3_d;
            hbl_q    <= hbl_d;
            vbl_q    <= vbl_d;
        end
    end

    assign bus.red      = rgb_p3_q[11:8];
    assign bus.green    = rgb_p3_q[7:4];
    assign bus.blue     = rgb_p3_q[3:0];
    assign bus.LHBL_dly = hbl_q[BLNK_DLY-1];
    assign bus.LVBL_dly = vbl_q[BLNK_DLY-1];

endmodule

// File: tb/tb_jtroadf_colmix.sv
// Directed bench for jtroadf_colmix: vector table streamed through the pipeline
// plus hand-written sequences for blanking, clock-enable hold, PROM collision and reset.
module tb_jtroadf_colmix;

    typedef struct {
        logic [3:0]  obj;
        logic [3:0]  scr;
        logic        h;
        logic        v;
        logic [13:0] exp;   // {red, green, blue, LHBL_dly, LVBL_dly}
    } vec_t;

    localparam int NV = 11;

    logic clk;
    logic rst;
    int   ntests;
    int   nfail;
    vec_t vecs [NV];

    jtroadf_colmix_if bus();

    jtroadf_colmix #(.BLNK_DLY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [13:0] exp);
        logic [13:0] got;
        got = {bus.red, bus.green, bus.blue, bus.LHBL_dly, bus.LVBL_dly};
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got rgb/h/v=%h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) bus.pxl_cen = 1'b1;
        @(negedge clk) bus.pxl_cen = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic prog(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.prog_en   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        @(negedge clk);
        bus.prog_en   = 1'b0;
    endtask

    task automatic apply(input logic [3:0] obj, input logic [3:0] scr, input logic h, input logic v);
        bus.obj_pxl = obj;
        bus.scr_pxl = scr;
        bus.LHBL    = h;
        bus.LVBL    = v;
    endtask

    initial begin
        logic [4:0] pa [8];
        logic [7:0] pd [8];
        ntests = 0;
        nfail  = 0;
        rst    = 1'b1;
        bus.pxl_cen   = 1'b0;
        bus.prog_en   = 1'b0;
        bus.prog_addr = 5'd0;
        bus.prog_data = 8'd0;
`ifdef JTROADF_GFXEN_EN
        bus.gfx_en    = 2'b11;
`endif
        apply(4'h0, 4'h0, 1'b1, 1'b1);

        pa = '{5'd16, 5'd5,  5'd20, 5'd3,  5'd25, 5'd31, 5'd15, 5'd1};
        pd = '{8'hFF, 8'h9D, 8'h00, 8'h5A, 8'h24, 8'hC0, 8'h3F, 8'h52};

        vecs[0]  = '{4'h0, 4'h0, 1'b1, 1'b1, {4'hF, 4'hF, 4'hF, 2'b11}};
        vecs[1]  = '{4'h5, 4'h9, 1'b1, 1'b1, {4'hB, 4'h6, 4'hA, 2'b11}};
        vecs[2]  = '{4'h0, 4'h9, 1'b1, 1'b1, {4'h9, 4'h9, 4'h0, 2'b11}};
        vecs[3]  = '{4'h3, 4'hF, 1'b1, 1'b1, {4'h4, 4'h6, 4'h5, 2'b11}};
        vecs[4]  = '{4'h0, 4'hF, 1'b1, 1'b1, {4'h0, 4'h0, 4'hF, 2'b11}};
        vecs[5]  = '{4'hF, 4'h0, 1'b1, 1'b1, {4'hF, 4'hF, 4'h0, 2'b11}};
        vecs[6]  = '{4'h1, 4'h0, 1'b0, 1'b1, {4'h0, 4'h0, 4'h0, 2'b01}};
        vecs[7]  = '{4'h1, 4'h0, 1'b1, 1'b1, {4'h4, 4'h4, 4'h5, 2'b11}};
        vecs[8]  = '{4'h5, 4'h9, 1'b1, 1'b0, {4'h0, 4'h0, 4'h0, 2'b10}};
        vecs[9]  = '{4'h0, 4'h0, 1'b0, 1'b0, {4'h0, 4'h0, 4'h0, 2'b00}};
        vecs[10] = '{4'h0, 4'h0, 1'b1, 1'b1, {4'hF, 4'hF, 4'hF, 2'b11}};

        for (int i = 0; i < 8; i++) prog(pa[i], pd[i]);
        @(negedge clk);
        chk("reset_state", 14'h0);
        rst = 1'b0;

        // Table streamed back-to-back; output lags input by three ticks
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) apply(vecs[i].obj, vecs[i].scr, vecs[i].h, vecs[i].v);
            tick();
            if (i >= 2) chk($sformatf("vec%0d", i - 2), vecs[i-2].exp);
            else        chk($sformatf("flush%0d", i), 14'h0);
        end

        // Clock enable low: everything holds while inputs churn
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d", i), {4'hF, 4'hF, 4'hF, 2'b11});
            bus.obj_pxl = 4'($urandom);
            bus.scr_pxl = 4'($urandom);
            bus.LHBL    = 1'($urandom);
            bus.LVBL    = 1'($urandom);
        end

        // One-tick LHBL pulse with fixed pixels
        apply(4'h5, 4'h9, 1'b1, 1'b1);
        repeat (3) tick();
        chk("pulse_pre", {4'hB, 4'h6, 4'hA, 2'b11});
        bus.LHBL = 1'b0;
        tick();
        chk("pulse_t1", {4'hB, 4'h6, 4'hA, 2'b11});
        bus.LHBL = 1'b1;
        tick();
        chk("pulse_t2", {4'hB, 4'h6, 4'hA, 2'b11});
        tick();
        chk("pulse_t3", {4'h0, 4'h0, 4'h0, 2'b01});
        tick();
        chk("pulse_t4", {4'hB, 4'h6, 4'hA, 2'b11});

        // PROM write landing on the same edge as the stage-2 read of index 20
        apply(4'h0, 4'h4, 1'b1, 1'b1);
        tick();
        @(negedge clk);
        bus.pxl_cen   = 1'b1;
        bus.prog_en   = 1'b1;
        bus.prog_addr = 5'd20;
        bus.prog_data = 8'h07;
        @(negedge clk);
        bus.pxl_cen   = 1'b0;
        bus.prog_en   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tick();
        chk("wr_old", {4'h0, 4'h0, 4'h0, 2'b11});
        tick();
        chk("wr_new", {4'hF, 4'h0, 4'h0, 2'b11});
        tick();
        chk("wr_steady", {4'hF, 4'h0, 4'h0, 2'b11});

        // Asynchronous reset mid-line, then refill
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async", 14'h0);
        @(negedge clk);
        rst = 1'b0;
        apply(4'h5, 4'h9, 1'b1, 1'b1);
        tick();
        chk("post_rst1", 14'h0);
        tick();
        chk("post_rst2", 14'h0);
        tick();
        chk("post_rst3", {4'hB, 4'h6, 4'hA, 2'b11});

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
